tinyalu_responder: RTL and testbench

- Responder end of the TinyALU start/done operand protocol. The TinyALU bus-functional model is the initiator.
- Samples A, B and op on start, computes the result, and returns a 16-bit result with a one-cycle done pulse.
- Single-cycle logic ops, multi-cycle pipelined multiply.
- Sits as the DUT behind the TinyALU BFM in the lab testbench.

---
 rtl/tinyalu_pkg.sv | 40 ++++
 rtl/tinyalu_mul_pipe.sv | 40 ++++
 rtl/tinyalu_responder.sv | 155 +++++++++++++++
 tb/tb_tinyalu_responder.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tinyalu_pkg.sv
// tinyalu_pkg: opcode and FSM state types shared by the TinyALU responder.
// Holds the single-cycle logic helper used by the SINGLE state.
package tinyalu_pkg;

    localparam int unsigned MUL_LATENCY_MAX = 8;
    localparam int unsigned CNT_W = $clog2(MUL_LATENCY_MAX);

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        rst_op = 3'b111
    } operation_t;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        MUL,
        HOLD
    } state_t;

    function automatic logic [15:0] alu_single(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [2:0] o
    );
        logic [15:0] r;
        r = '0;
        unique case (o)
            add_op:  r = {7'b0, {1'b0, a} + {1'b0, b}};
            and_op:  r = {8'b0, a & b};
            xor_op:  r = {8'b0, a ^ b};
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tinyalu_mul_pipe.sv
// tinyalu_mul_pipe: registered 8x8 unsigned multiplier, LATENCY stages.
// A valid bit travels alongside each product; reset clears only the valids.
module tinyalu_mul_pipe #(
    parameter int unsigned LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        valid_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic        valid_o,
    output logic [15:0] prod_o
);

    logic [LATENCY-1:0] vld_q;
    logic [15:0]        prod_q [LATENCY];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Data path needs no reset: it is qualified by the valid chain.
    always_ff @(posedge clk) begin
        prod_q[0] <= 16'(a_i) * 16'(b_i);
        for (int i = 1; i < LATENCY; i++) begin
            prod_q[i] <= prod_q[i-1];
        end
    end

    assign valid_o = vld_q[LATENCY-1];
    assign prod_o  = prod_q[LATENCY-1];

endmodule

// File: rtl/tinyalu_responder.sv
// tinyalu_responder: responder end of the TinyALU start/done protocol.
// Define TINYALU_ILLEGAL_OP_ERR_EN to add the err pulse for codes 101/110.
module tinyalu_responder
    import tinyalu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        done,
    output logic [15:0] result
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    ,
    output logic        err
`endif
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LATENCY - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       a_q, a_d;
    logic [7:0]       b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [15:0]      result_q, result_d;
    logic             done_q, done_d;

    logic             is_single;
    logic             is_mul;
    logic             mul_go;
    logic             mul_vld;
    logic [15:0]      mul_prod;

    assign is_single = (op == add_op) || (op == and_op) || (op == xor_op);
    assign is_mul    = (op == mul_op);

`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    logic is_ill;
    logic err_q, err_d;

    assign is_ill = (op == 3'b101) || (op == 3'b110);
    assign err    = err_q;
`endif

    tinyalu_mul_pipe #(
        .LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .valid_i (mul_go),
        .a_i     (A),
        .b_i     (B),
        .valid_o (mul_vld),
        .prod_o  (mul_prod)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            done_q   <= done_d;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        done_d   = 1'b0;
        mul_go   = 1'b0;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
        err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        is_single: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            state_d = SINGLE;
                        end
                        is_mul: begin
                            a_d     = A;
                            b_d     = B;
                            op_d    = op;
                            cnt_d   = CNT_INIT;
                            mul_go  = 1'b1;
                            state_d = MUL;
                        end
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
                        is_ill: begin
                            err_d   = 1'b1;
                            state_d = HOLD;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            SINGLE: begin
                result_d = alu_single(a_q, b_q, op_q);
                done_d   = 1'b1;
                state_d  = HOLD;
            end
            MUL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                // Counter and valid chain reach the end on the same edge.
                if (mul_vld) begin
                    result_d = mul_prod;
                    done_d   = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_tinyalu_responder.sv
// tb_tinyalu_responder: directed plus random checks of the TinyALU responder
// against an arithmetic reference model of the operand protocol.
module tb_tinyalu_responder;

    localparam int ML = 3;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
    logic        err;
`endif

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_res;

    always #5 clk = ~clk;

    tinyalu_responder #(
        .MUL_LATENCY (ML)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
        ,
        .err     (err)
`endif
    );

    function automatic logic [15:0] model(input int a, input int b, input int o);
        int r;
        case (o)
            1:       r = a + b;
            2:       r = a & b;
            3:       r = a ^ b;
            4:       r = a * b;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    function automatic int model_lat(input int o);
        return (o == 4) ? ML : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic do_op(input int a, input int b, input int o, input int hold);
        int   lat;
        int   pulses;
        bit   seen;
        bit   stable;
        logic [15:0] e;
        e = model(a, b, o);
        @(negedge clk);
        A = 8'(a);
        B = 8'(b);
        op = 3'(o);
        start = 1'b1;
        @(posedge clk);
        #1;
        seen = 0;
        lat = 0;
        stable = 1;
        @(negedge clk);
        A = 8'($urandom);
        B = 8'($urandom);
        op = 3'($urandom);
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1;
                lat = c;
            end else if (result !== exp_res) begin
                stable = 0;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("done_latency", lat, model_lat(o));
        check("result_stable_before_done", 32'(stable), 32'd1);
        check("result", result, e);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 1'b0);
        pulses = 0;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk);
            #1;
            pulses += int'(done);
        end
        if (hold > 0) check("no_retrigger_in_hold", pulses, 0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        exp_res = e;
    endtask

    task automatic do_noop(input int o);
        int pulses;
        @(negedge clk);
        A = 8'($urandom);
        B = 8'($urandom);
        op = 3'(o);
        start = 1'b1;
        @(posedge clk);
        #1;
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
        check("err_pulse", err, 1'((o == 5) || (o == 6)));
`endif
        pulses = int'(done);
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            pulses += int'(done);
`ifdef TINYALU_ILLEGAL_OP_ERR_EN
            if (c == 0) check("err_one_cycle", err, 1'b0);
`endif
        end
        check("noop_no_done", pulses, 0);
        check("noop_result_kept", result, exp_res);
    endtask

    initial begin
        int pulses;
        reset_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        op = '0;
        exp_res = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_done", done, 1'b0);
        check("reset_result", result, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            pulses += int'(done);
        end
        check("idle_no_done", pulses, 0);

        do_op(8'hFF, 8'h01, 1, 0);
        check("add_carry", result, 16'h0100);
        do_op(8'hFF, 8'hFF, 4, 0);
        check("mul_ff_ff", result, 16'hFE01);
        do_op(8'hF0, 8'h3C, 2, 0);
        check("and_f0_3c", result, 16'h0030);
        do_op(8'hF0, 8'h3C, 3, 0);
        check("xor_f0_3c", result, 16'h00CC);
        do_noop(0);
        check("noop_keeps_cc", result, 16'h00CC);
        do_op(8'h12, 8'h34, 1, 4);
        do_op(8'hAA, 8'h55, 3, 0);
        check("xor_aa_55", result, 16'h00FF);
        do_noop(5);
        do_noop(6);
        do_noop(7);

        for (int i = 0; i < 30; i++) begin
            int o;
            o = $urandom_range(0, 7);
            if (o >= 1 && o <= 4) begin
                do_op($urandom_range(0, 255), $urandom_range(0, 255), o, $urandom_range(0, 2));
            end else begin
                do_noop(o);
            end
        end

        do_op(8'h20, 8'h30, 4, 0);
        @(negedge clk);
        A = 8'h10;
        B = 8'h10;
        op = 3'd4;
        start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        check("midmul_reset_result", result, 16'h0000);
        check("midmul_reset_done", done, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_res = 16'h0000;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            pulses += int'(done);
        end
        check("midmul_no_done", pulses, 0);
        check("midmul_result_zero", result, 16'h0000);
        do_op(8'h07, 8'h09, 4, 1);
        check("mul_after_reset", result, 16'h003F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
